// File: rtl/energy_pkg.sv
// rtl/energy_pkg.sv - shared types and sizing helpers for energy_scale_accum
package energy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } rd_state_t;

    localparam int ACC_W_DEFAULT = 24;
    localparam int ACC_BYTES     = ACC_W_DEFAULT / 8;

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int acc_bytes(input int acc_w);
        return acc_w / 8;
    endfunction

endpackage

// File: rtl/energy_scale_accum_if.sv
// rtl/energy_scale_accum_if.sv - sample, scaled-sample and readout signals of energy_scale_accum
interface energy_scale_accum_if
    import energy_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NCH        = 4,
    parameter int GAIN_SHIFT = 1
);
    localparam int CH_W = ch_width(NCH);

    logic                         in_valid;
    logic [CH_W-1:0]              in_ch;
    logic [DATA_W-1:0]            in_data;
    logic                         sc_valid;
    logic [CH_W-1:0]              sc_ch;
    logic [DATA_W+GAIN_SHIFT-1:0] sc_data;
    logic                         rd_req;
    logic [CH_W-1:0]              rd_ch;
    logic                         rd_busy;
    logic                         byte_valid;
    logic [7:0]                   byte_out;
    logic [NCH-1:0]               sat;

    modport master (
        output in_valid, in_ch, in_data, rd_req, rd_ch,
        input  sc_valid, sc_ch, sc_data, rd_busy, byte_valid, byte_out, sat
    );

    modport slave (
        input  in_valid, in_ch, in_data, rd_req, rd_ch,
        output sc_valid, sc_ch, sc_data, rd_busy, byte_valid, byte_out, sat
    );

endinterface

// File: rtl/energy_scale_accum_sat_adder.sv
// rtl/energy_scale_accum_sat_adder.sv - unsigned saturating adder with overflow flag
module sat_adder #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign ovf = raw[W];
    assign sum = raw[W] ? {W{1'b1}} : raw[W-1:0];

endmodule

// File: rtl/energy_scale_accum.sv
// rtl/energy_scale_accum.sv - scales multiplexed power samples and integrates them per channel
module energy_scale_accum
    import energy_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int NCH           = 4,
    parameter int GAIN_SHIFT    = 1,
    parameter int ACC_W         = ACC_W_DEFAULT,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    energy_scale_accum_if.slave  bus
);
    localparam int CH_W   = ch_width(NCH);
    localparam int SC_W   = DATA_W + GAIN_SHIFT;
    localparam int NBYTES = acc_bytes(ACC_W);
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic              sc_valid_q;
    logic [CH_W-1:0]   sc_ch_q;
    logic [SC_W-1:0]   sc_data_q;

    logic [ACC_W-1:0]  acc [NCH];
    logic [NCH-1:0]    sat_q;
    logic [ACC_W-1:0]  sc_ext;
    logic [ACC_W-1:0]  sum;
    logic              ovf;

    rd_state_t         state;
    logic [CH_W-1:0]   rd_ch_q;
    logic [ACC_W-1:0]  snap;
    logic [CNT_W-1:0]  cnt;
    logic              rd_busy_q;
    logic              byte_valid_q;
    logic [7:0]        byte_q;
    logic [ACC_W-1:0]  acc_rd;
    logic              collide;

    assign sc_ext  = ACC_W'(sc_data_q);
    assign acc_rd  = acc[rd_ch_q];
    assign collide = sc_valid_q && (sc_ch_q == rd_ch_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_valid_q <= 1'b0;
            sc_ch_q    <= '0;
            sc_data_q  <= '0;
        end else if (ena) begin
            sc_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sc_ch_q   <= bus.in_ch;
                sc_data_q <= {bus.in_data, {GAIN_SHIFT{1'b0}}};
            end
        end
    end

    sat_adder #(.W(ACC_W)) u_sat_adder (
        .a   (acc[sc_ch_q]),
        .b   (sc_ext),
        .sum (sum),
        .ovf (ovf)
    );

    // The clear in LOAD is written after the add so it wins; a colliding sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) acc[i] <= '0;
            sat_q <= '0;
        end else if (ena) begin
            if (sc_valid_q) begin
                acc[sc_ch_q] <= sum;
                if (ovf) sat_q[sc_ch_q] <= 1'b1;
            end
            if (state == ST_LOAD && CLEAR_ON_READ) begin
                acc[rd_ch_q]   <= collide ? sc_ext : '0;
                sat_q[rd_ch_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rd_ch_q      <= '0;
            snap         <= '0;
            cnt          <= '0;
            rd_busy_q    <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_q       <= '0;
        end else if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (bus.rd_req) begin
                        state     <= ST_LOAD;
                        rd_ch_q   <= bus.rd_ch;
                        rd_busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    byte_q       <= acc_rd[ACC_W-1 -: 8];
                    snap         <= acc_rd << 8;
                    byte_valid_q <= 1'b1;
                    cnt          <= CNT_W'(NBYTES - 1);
                    state        <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        byte_valid_q <= 1'b0;
                        rd_busy_q    <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        byte_q <= snap[ACC_W-1 -: 8];
                        snap   <= snap << 8;
                        cnt    <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sc_valid   = sc_valid_q;
    assign bus.sc_ch      = sc_ch_q;
    assign bus.sc_data    = sc_data_q;
    assign bus.rd_busy    = rd_busy_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_out   = byte_q;
    assign bus.sat        = sat_q;

endmodule

// File: tb/tb_energy_scale_accum.sv
// tb/tb_energy_scale_accum.sv - directed self-checking bench for energy_scale_accum
module tb_energy_scale_accum;

    logic clk;
    logic rst_n;
    logic ena;
    int   total;
    int   bad;

    energy_scale_accum_if #(.DATA_W(8), .NCH(4), .GAIN_SHIFT(1)) bus ();

    energy_scale_accum #(
        .DATA_W(8), .NCH(4), .GAIN_SHIFT(1), .ACC_W(24), .CLEAR_ON_READ(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] data);
        bus.in_valid = 1'b1;
        bus.in_ch    = ch;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic read_ch(input logic [1:0] ch, output logic [23:0] v, output bit timing_ok);
        v = '0;
        bus.rd_ch  = ch;
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req   = 1'b0;
        bus.in_valid = 1'b0;
        timing_ok = (bus.rd_busy === 1'b1) && (bus.byte_valid === 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            timing_ok = timing_ok && (bus.byte_valid === 1'b1) && (bus.rd_busy === 1'b1);
            v = {v[15:0], bus.byte_out};
        end
        tick();
        timing_ok = timing_ok && (bus.byte_valid === 1'b0) && (bus.rd_busy === 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.sc_valid, bus.rd_busy, bus.byte_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=000", {bus.sc_valid, bus.rd_busy, bus.byte_valid});
        end
        total++;
        if ({bus.sc_data, bus.byte_out, bus.sat} !== 21'd0) begin
            bad++;
            $display("FAIL reset_data got=%0h exp=0", {bus.sc_data, bus.byte_out, bus.sat});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scale();
        send(2'd0, 8'd25);
        total++;
        if ({bus.sc_valid, bus.sc_ch, bus.sc_data} !== {1'b1, 2'd0, 9'd50}) begin
            bad++;
            $display("FAIL scale_25 got=%0h exp=%0h", {bus.sc_valid, bus.sc_ch, bus.sc_data}, {1'b1, 2'd0, 9'd50});
        end
        send(2'd0, 8'd45);
        total++;
        if ({bus.sc_valid, bus.sc_ch, bus.sc_data} !== {1'b1, 2'd0, 9'd90}) begin
            bad++;
            $display("FAIL scale_45 got=%0h exp=%0h", {bus.sc_valid, bus.sc_ch, bus.sc_data}, {1'b1, 2'd0, 9'd90});
        end
        tick();
        total++;
        if ({bus.sc_valid, bus.sc_data} !== {1'b0, 9'd90}) begin
            bad++;
            $display("FAIL scale_hold got=%0h exp=%0h", {bus.sc_valid, bus.sc_data}, {1'b0, 9'd90});
        end
        send(2'd3, 8'd255);
        total++;
        if ({bus.sc_ch, bus.sc_data} !== {2'd3, 9'd510}) begin
            bad++;
            $display("FAIL scale_max got=%0h exp=%0h", {bus.sc_ch, bus.sc_data}, {2'd3, 9'd510});
        end
        tick();
        begin
            logic [23:0] v;
            bit ok;
            read_ch(2'd3, v, ok);
        end
    endtask

    task automatic test_readout();
        logic [23:0] v;
        bit ok;
        send(2'd2, 8'd10);
        send(2'd2, 8'd20);
        send(2'd2, 8'd30);
        tick();
        read_ch(2'd2, v, ok);
        total++;
        if (v !== 24'h000078) begin
            bad++;
            $display("FAIL read_ch2 got=%h exp=000078", v);
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL read_ch2_timing got=%b exp=1", ok);
        end
        read_ch(2'd2, v, ok);
        total++;
        if ({ok, v} !== {1'b1, 24'h000000}) begin
            bad++;
            $display("FAIL reread_ch2 got=%h exp=1000000", {ok, v});
        end
    endtask

    task automatic test_saturate();
        logic [23:0] v;
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd1;
        bus.in_data  = 8'd255;
        repeat (32896) tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        total++;
        if (bus.sat !== 4'b0000) begin
            bad++;
            $display("FAIL sat_below got=%b exp=0000", bus.sat);
        end
        send(2'd1, 8'd255);
        tick();
        total++;
        if (bus.sat !== 4'b0010) begin
            bad++;
            $display("FAIL sat_set got=%b exp=0010", bus.sat);
        end
        read_ch(2'd1, v, ok);
        total++;
        if ({ok, v} !== {1'b1, 24'hFFFFFF}) begin
            bad++;
            $display("FAIL sat_read got=%h exp=1ffffff", {ok, v});
        end
        total++;
        if (bus.sat !== 4'b0000) begin
            bad++;
            $display("FAIL sat_clear got=%b exp=0000", bus.sat);
        end
    endtask

    task automatic test_collision();
        logic [23:0] v;
        bit ok;
        send(2'd3, 8'd50);
        tick();
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd3;
        bus.in_data  = 8'd25;
        read_ch(2'd3, v, ok);
        total++;
        if ({ok, v} !== {1'b1, 24'd100}) begin
            bad++;
            $display("FAIL collide_snap got=%h exp=%h", {ok, v}, {1'b1, 24'd100});
        end
        read_ch(2'd3, v, ok);
        total++;
        if (v !== 24'd50) begin
            bad++;
            $display("FAIL collide_acc got=%h exp=%h", v, 24'd50);
        end
    endtask

    task automatic test_enable();
        logic [23:0] v;
        bit ok;
        bit seen;
        seen = 1'b0;
        ena          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_ch    = 2'd0;
        bus.in_data  = 8'd7;
        bus.rd_ch    = 2'd0;
        for (int i = 0; i < 5; i++) begin
            bus.rd_req = (i % 2 == 0);
            tick();
            if (bus.sc_valid !== 1'b0 || bus.byte_valid !== 1'b0 || bus.rd_busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL ena_freeze got=%b exp=0", seen);
        end
        bus.in_valid = 1'b0;
        bus.rd_req   = 1'b0;
        ena          = 1'b1;
        tick();
        total++;
        if ({bus.rd_busy, bus.sc_valid} !== 2'b00) begin
            bad++;
            $display("FAIL ena_noqueue got=%b exp=00", {bus.rd_busy, bus.sc_valid});
        end
        read_ch(2'd0, v, ok);
        total++;
        if ({ok, v} !== {1'b1, 24'd140}) begin
            bad++;
            $display("FAIL ena_acc got=%h exp=%h", {ok, v}, {1'b1, 24'd140});
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] v;
        bit ok;
        send(2'd2, 8'd5);
        send(2'd3, 8'd9);
        tick();
        bus.rd_ch  = 2'd2;
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
        total++;
        if ({bus.byte_valid, bus.byte_out} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL mid_first got=%h exp=100", {bus.byte_valid, bus.byte_out});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.byte_valid, bus.rd_busy, bus.sc_valid, bus.sat} !== 7'd0) begin
            bad++;
            $display("FAIL mid_async got=%b exp=0", {bus.byte_valid, bus.rd_busy, bus.sc_valid, bus.sat});
        end
        tick();
        total++;
        if (bus.byte_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_hold got=%b exp=0", bus.byte_valid);
        end
        rst_n = 1'b1;
        tick();
        read_ch(2'd2, v, ok);
        total++;
        if ({ok, v} !== {1'b1, 24'd0}) begin
            bad++;
            $display("FAIL mid_ch2 got=%h exp=1000000", {ok, v});
        end
        read_ch(2'd3, v, ok);
        total++;
        if ({ok, v} !== {1'b1, 24'd0}) begin
            bad++;
            $display("FAIL mid_ch3 got=%h exp=1000000", {ok, v});
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        ena          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_ch    = '0;
        bus.in_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_ch    = '0;
        test_reset();
        test_scale();
        test_readout();
        test_saturate();
        test_collision();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/energy_scale_accum.md
Name: energy_scale_accum

Overview:
- Parametrised successor to the single-channel doubling converter in the tt_um_vedm_industries top.
- Accepts time-multiplexed 8-bit power samples from NCH renewable sources (PV, wind, ...).
- Emits each sample scaled by 2^GAIN_SHIFT after one cycle.
- Integrates the scaled samples into per-channel saturating energy accumulators; any accumulator can be read out as a byte stream over the 8-bit output path.

Parameters:
- DATA_W, 8: input sample width.
- NCH, 4: number of channels; power of two, 2..8.
- GAIN_SHIFT, 1: left-shift applied to samples (1 = x2).
- ACC_W, 24: accumulator width; a multiple of 8.
- CLEAR_ON_READ, 1: 1 = accumulator is zeroed when a readout snapshot is taken.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- ena, in, 1: global enable; 0 freezes all state.
- in_valid, in, 1: sample strobe.
- in_ch, in, CH_W = clog2(NCH): sample channel.
- in_data, in, DATA_W: sample value, unsigned.
- sc_valid, out, 1: scaled sample valid.
- sc_ch, out, CH_W: channel of the scaled sample.
- sc_data, out, DATA_W+GAIN_SHIFT: scaled sample.
- rd_req, in, 1: readout request (single-cycle pulse).
- rd_ch, in, CH_W: channel to read.
- rd_busy, out, 1: readout in progress.
- byte_valid, out, 1: byte_out valid.
- byte_out, out, 8: accumulator byte, MSB first.
- sat, out, NCH: sticky per-channel saturation flags.

Behaviour:
- Reset: all outputs 0, all accumulators 0, sat 0, FSM in IDLE. Reset is asynchronous and can occur mid-readout; the stream aborts with no further byte_valid.
- ena=0: no register updates; in_valid and rd_req are ignored (dropped, not queued). Outputs hold their values.
- Scale stage: when in_valid and ena are high, on the next edge sc_valid=1, sc_data = in_data << GAIN_SHIFT (zero-extended, no loss), sc_ch = in_ch. Otherwise sc_valid=0 and sc_data/sc_ch hold.
- Accumulate: in the cycle sc_valid=1, acc[sc_ch] <= acc[sc_ch] + sc_data. If the sum exceeds 2^ACC_W-1, acc is clamped to all-ones and sat[sc_ch] is set. sat clears only on reset, or on a clear-on-read of that channel.
- Readout FSM, IDLE -> LOAD -> SHIFT -> IDLE:
  - IDLE: rd_req with ena -> LOAD, rd_busy=1 next cycle.
  - LOAD, 1 cycle: snap <= acc[rd_ch latched] (pre-add value of this cycle). If CLEAR_ON_READ, acc and sat of that channel are cleared. Simultaneous accumulate to the same channel: acc <= sc_data; the add is not lost.
  - SHIFT: ACC_W/8 cycles with byte_valid=1, byte_out = snap MSB byte first, then the next-lower bytes.
  - After the last byte -> IDLE; rd_busy and byte_valid drop on the same edge.
- rd_req while rd_busy is ignored.
- Latency: rd_req at cycle t gives the first byte at t+2 and the last at t+1+ACC_W/8.
- Accumulation on all channels continues during SHIFT.

Decomposition:
- Package energy_pkg holds:
  - FSM state enum (IDLE, LOAD, SHIFT).
  - CH_W derivation function.
  - Byte-count constant ACC_W/8.
- One sub-module, sat_adder: a parametrised ACC_W unsigned saturating adder with overflow flag.
- Instantiate it once, muxed on sc_ch.

Test Plan:
- Reset released, ch0 in_data=25 (0x19) then 45 (0x2D) -> sc_data=50 (0x32), then 90 (0x5A), each one cycle after strobe, sc_ch=0.
- ch2 given samples 10, 20, 30, then read ch2 -> bytes 0x00, 0x00, 0x78 (120) on three consecutive cycles starting 2 cycles after rd_req; re-read -> all 0x00 (CLEAR_ON_READ=1).
- ch1 preloaded near full by repeated 255 samples until the sum exceeds 0xFFFFFF -> acc clamps to 0xFFFFFF, sat[1]=1; read -> 0xFF, 0xFF, 0xFF; sat[1]=0 afterwards.
- Collision: ch3 acc=100; rd_req ch3 with sc_valid=1, sc_data=50 in the LOAD cycle -> streamed value 100, acc[3]=50 afterwards.
- ena=0 for 5 cycles with in_valid=1 and rd_req pulses -> no sc_valid, no byte_valid, accumulators unchanged.
- rst_n asserted after the first byte of a readout -> byte_valid=0 and rd_busy=0 immediately; all acc=0; a subsequent read returns zeros.
